// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-PC sequencer and anything that traces
// which source last wrote r_pc.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_ACT,
      ST_START,
      ST_RUN,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_RESET,
      SRC_TRAP,
      SRC_BR,
      SRC_SEQ
   } src_e;

   localparam logic [31:0] BOOT_PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the reset-unit, redirect, fetch and r_pc register signals around the
// sequencer. master is the sequencer side; slave is the core environment side.
interface pc_sequencer_if;
   import pc_seq_pkg::*;

   logic        RSTU_ACT;
   logic [31:0] RSTU_PC_D;
   logic        RSTU_PC_WE;
   logic        TRAP_VLD;
   logic [31:0] TRAP_PC;
   logic        BR_VLD;
   logic [31:0] BR_PC;
   logic        FETCH_FIRE;
   logic        DBG_HALT;
   logic [31:0] r_pc_Q;
   logic [31:0] r_pc_D;
   logic        r_pc_WE;
   logic        FETCH_EN;
   logic        FLUSH;
   logic        HALTED;
   src_e        PC_SRC;

   modport master (
      input  RSTU_PC_D, RSTU_PC_WE, TRAP_VLD, TRAP_PC, BR_VLD, BR_PC,
             FETCH_FIRE, DBG_HALT, r_pc_Q,
      output RSTU_ACT, r_pc_D, r_pc_WE, FETCH_EN, FLUSH, HALTED, PC_SRC
   );

   modport slave (
      output RSTU_PC_D, RSTU_PC_WE, TRAP_VLD, TRAP_PC, BR_VLD, BR_PC,
             FETCH_FIRE, DBG_HALT, r_pc_Q,
      input  RSTU_ACT, r_pc_D, r_pc_WE, FETCH_EN, FLUSH, HALTED, PC_SRC
   );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational priority select for the next r_pc write: reset vector, trap,
// branch redirect, then sequential fetch-block advance.
module pc_next_mux
   import pc_seq_pkg::*;
#(
   parameter int unsigned FETCH_BYTES = 8
) (
   input  state_e      state,
   input  logic        rst,
   input  logic [31:0] rstu_pc_d,
   input  logic        rstu_pc_we,
   input  logic        trap_vld,
   input  logic [31:0] trap_pc,
   input  logic        br_vld,
   input  logic [31:0] br_pc,
   input  logic        fetch_fire,
   input  logic [31:0] r_pc_q,
   output logic [31:0] r_pc_d,
   output logic        r_pc_we,
   output logic        flush,
   output src_e        src
);

   localparam logic [31:0] FETCH_INC = 32'(FETCH_BYTES);
   localparam logic [31:0] BLK_MASK  = ~(FETCH_INC - 32'd1);

   always_comb begin
      r_pc_d  = '0;
      r_pc_we = 1'b0;
      flush   = 1'b0;
      src     = SRC_NONE;
      if (!rst) begin
         case (state)
            ST_ACT: begin
               r_pc_d  = rstu_pc_d;
               r_pc_we = rstu_pc_we;
               flush   = 1'b1;
               src     = SRC_RESET;
            end
            ST_RUN, ST_HALT: begin
               if (trap_vld) begin
                  r_pc_d  = trap_pc & BOOT_PC_ALIGN_MASK;
                  r_pc_we = 1'b1;
                  flush   = 1'b1;
                  src     = SRC_TRAP;
               end else if (br_vld) begin
                  r_pc_d  = br_pc & BOOT_PC_ALIGN_MASK;
                  r_pc_we = 1'b1;
                  flush   = 1'b1;
                  src     = SRC_BR;
               end else if (fetch_fire && (state == ST_RUN)) begin
                  // Advance from the start of the current block; the add wraps at 2^32.
                  r_pc_d  = (r_pc_q & BLK_MASK) + FETCH_INC;
                  r_pc_we = 1'b1;
                  src     = SRC_SEQ;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Sole writer of the architectural fetch PC: boot hold/ACT sequence, then
// redirect/advance arbitration with debug halt.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES = 4,
   parameter int unsigned FETCH_BYTES       = 8
) (
   input  logic           CLK,
   input  logic           RST,
   pc_sequencer_if.master bus
);

   localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == 8'd0) state_d = ST_ACT;
            else               cnt_d   = cnt_q - 8'd1;
         end
         ST_ACT:   state_d = ST_START;
         ST_START: state_d = bus.DBG_HALT ? ST_HALT : ST_RUN;
         ST_RUN:   if (bus.DBG_HALT) state_d = ST_HALT;
         ST_HALT:  if (!bus.DBG_HALT) state_d = ST_RUN;
         default:  state_d = ST_HOLD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_HOLD;
         cnt_q   <= HOLD_INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset forces every control output low even before the state register settles.
   assign bus.RSTU_ACT = !RST && (state_q == ST_ACT);
   assign bus.FETCH_EN = !RST && (state_q == ST_RUN);
   assign bus.HALTED   = !RST && (state_q == ST_HALT);

   pc_next_mux #(
      .FETCH_BYTES (FETCH_BYTES)
   ) u_next_mux (
      .state      (state_q),
      .rst        (RST),
      .rstu_pc_d  (bus.RSTU_PC_D),
      .rstu_pc_we (bus.RSTU_PC_WE),
      .trap_vld   (bus.TRAP_VLD),
      .trap_pc    (bus.TRAP_PC),
      .br_vld     (bus.BR_VLD),
      .br_pc      (bus.BR_PC),
      .fetch_fire (bus.FETCH_FIRE),
      .r_pc_q     (bus.r_pc_Q),
      .r_pc_d     (bus.r_pc_D),
      .r_pc_we    (bus.r_pc_WE),
      .flush      (bus.FLUSH),
      .src        (bus.PC_SRC)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle reference model, directed vector table,
// hand-written halt/reset sequences and a randomized run.
module tb_pc_sequencer;

   localparam int          H  = 4;
   localparam logic [31:0] FB = 32'd8;

   logic CLK = 1'b0;
   logic RST;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_HOLD_CYCLES (H),
      .FETCH_BYTES       (8)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Model state: non-reset cycles completed since the last reset cycle, and
   // whether DBG_HALT was high in the previous operational cycle.
   int   ok        = 0;
   logic m_halted  = 1'b0;

   logic        obs_act, obs_en, obs_hl, obs_fl, obs_we;
   logic [31:0] obs_d;

   typedef struct {
      logic        trap_vld;
      logic [31:0] trap_pc;
      logic        br_vld;
      logic [31:0] br_pc;
      logic        fire;
      logic [31:0] q;
      logic        exp_we;
      logic [31:0] exp_d;
      logic        exp_flush;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.TRAP_VLD   = 1'b0;
      bus.TRAP_PC    = '0;
      bus.BR_VLD     = 1'b0;
      bus.BR_PC      = '0;
      bus.FETCH_FIRE = 1'b0;
      bus.DBG_HALT   = 1'b0;
      bus.r_pc_Q     = 32'h0000_1000;
      bus.RSTU_PC_D  = 32'h0000_1000;
      bus.RSTU_PC_WE = 1'b1;
   endtask

   // One clock cycle: compare against the model mid-cycle, then advance the model.
   task automatic step();
      int          n;
      logic        e_act, e_en, e_hl, e_fl, e_we;
      logic [31:0] e_d;
      @(negedge CLK);
      n = ok + 1;
      e_act = 1'b0; e_en = 1'b0; e_hl = 1'b0; e_fl = 1'b0; e_we = 1'b0; e_d = '0;
      if (!RST) begin
         if (n == H + 1) begin
            e_act = 1'b1;
            e_fl  = 1'b1;
            e_we  = bus.RSTU_PC_WE;
            e_d   = bus.RSTU_PC_D;
         end else if (n > H + 2) begin
            e_en = !m_halted;
            e_hl = m_halted;
            if (bus.TRAP_VLD) begin
               e_we = 1'b1; e_fl = 1'b1;
               e_d  = bus.TRAP_PC - (bus.TRAP_PC % 32'd4);
            end else if (bus.BR_VLD) begin
               e_we = 1'b1; e_fl = 1'b1;
               e_d  = bus.BR_PC - (bus.BR_PC % 32'd4);
            end else if (!m_halted && bus.FETCH_FIRE) begin
               e_we = 1'b1;
               e_d  = bus.r_pc_Q - (bus.r_pc_Q % FB) + FB;
            end
         end
      end
      obs_act = bus.RSTU_ACT; obs_en = bus.FETCH_EN; obs_hl = bus.HALTED;
      obs_fl  = bus.FLUSH;    obs_we = bus.r_pc_WE;  obs_d  = bus.r_pc_D;
      chk("model_rstu_act", 32'(obs_act), 32'(e_act));
      chk("model_fetch_en", 32'(obs_en), 32'(e_en));
      chk("model_halted",   32'(obs_hl), 32'(e_hl));
      chk("model_flush",    32'(obs_fl), 32'(e_fl));
      chk("model_r_pc_we",  32'(obs_we), 32'(e_we));
      if (e_we || RST) chk("model_r_pc_d", obs_d, e_d);
      @(posedge CLK);
      if (!RST && n >= H + 2) m_halted = bus.DBG_HALT;
      ok = RST ? 0 : ok + 1;
      #1;
   endtask

   // With RST low, step until RSTU_ACT is seen; idx is the 1-based cycle, -1 if never.
   task automatic find_act(output int idx);
      idx = -1;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (obs_act) begin
            idx = i;
            break;
         end
      end
   endtask

   initial begin
      int act_idx;
      int en_idx;

      vecs[0] = '{1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h0000_1004, 1'b1, 32'h0000_1008, 1'b0};
      vecs[1] = '{1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0000_0000, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0003,  1'b1, 32'h0000_2000,  1'b1, 32'h0000_1234, 1'b1, 32'h8000_0000, 1'b1};
      vecs[3] = '{1'b0, 32'h0,          1'b1, 32'h0000_2010,  1'b0, 32'h0000_1234, 1'b1, 32'h0000_2010, 1'b1};
      vecs[4] = '{1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0000_5000, 1'b0, 32'h0000_0000, 1'b0};
      vecs[5] = '{1'b0, 32'h0,          1'b0, 32'h0000_0000,  1'b1, 32'h0000_101F, 1'b1, 32'h0000_1020, 1'b0};

      clear_inputs();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      ok = 0;

      // Boot: three reset cycles, then measure ACT and first FETCH_EN.
      for (int i = 0; i < 3; i++) step();
      chk("reset_r_pc_we", 32'(obs_we), 32'd0);
      chk("reset_r_pc_d",  obs_d,       32'd0);
      RST = 1'b0;
      act_idx = -1;
      en_idx  = -1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (obs_act && act_idx < 0) begin
            act_idx = i;
            chk("boot_act_we", 32'(obs_we), 32'd1);
            chk("boot_act_d",  obs_d,       32'h0000_1000);
         end
         if (obs_en && en_idx < 0) en_idx = i;
      end
      chk("boot_act_cycle",      32'(act_idx), 32'(H + 1));
      chk("boot_fetch_en_cycle", 32'(en_idx),  32'(H + 3));

      // Directed RUN vectors.
      foreach (vecs[i]) begin
         bus.TRAP_VLD   = vecs[i].trap_vld;
         bus.TRAP_PC    = vecs[i].trap_pc;
         bus.BR_VLD     = vecs[i].br_vld;
         bus.BR_PC      = vecs[i].br_pc;
         bus.FETCH_FIRE = vecs[i].fire;
         bus.r_pc_Q     = vecs[i].q;
         step();
         chk($sformatf("vec%0d_we", i),    32'(obs_we), 32'(vecs[i].exp_we));
         chk($sformatf("vec%0d_flush", i), 32'(obs_fl), 32'(vecs[i].exp_flush));
         if (vecs[i].exp_we) chk($sformatf("vec%0d_d", i), obs_d, vecs[i].exp_d);
      end
      clear_inputs();

      // Halt entry: the advance in the requesting cycle still commits.
      bus.DBG_HALT   = 1'b1;
      bus.FETCH_FIRE = 1'b1;
      bus.r_pc_Q     = 32'h0000_2000;
      step();
      chk("halt_entry_en", 32'(obs_en), 32'd1);
      chk("halt_entry_d",  obs_d,       32'h0000_2008);
      step();
      chk("halt_halted",   32'(obs_hl), 32'd1);
      chk("halt_fetch_en", 32'(obs_en), 32'd0);
      chk("halt_fire_we",  32'(obs_we), 32'd0);
      bus.BR_VLD = 1'b1;
      bus.BR_PC  = 32'h0000_3000;
      step();
      chk("halt_br_we",    32'(obs_we), 32'd1);
      chk("halt_br_d",     obs_d,       32'h0000_3000);
      chk("halt_br_flush", 32'(obs_fl), 32'd1);
      bus.BR_VLD     = 1'b0;
      bus.FETCH_FIRE = 1'b0;
      bus.DBG_HALT   = 1'b0;
      step();
      chk("release_still_halted", 32'(obs_hl), 32'd1);
      step();
      chk("release_fetch_en", 32'(obs_en), 32'd1);
      chk("release_halted",   32'(obs_hl), 32'd0);

      // Reset while HOLD counter is at 1.
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();
      step();
      RST = 1'b1;
      step();
      chk("midhold_act", 32'(obs_act), 32'd0);
      chk("midhold_we",  32'(obs_we),  32'd0);
      RST = 1'b0;
      find_act(act_idx);
      chk("midhold_reboot_act_cycle", 32'(act_idx), 32'(H + 1));
      step();

      // Reset landing on the ACT cycle.
      RST = 1'b1;
      step();
      RST = 1'b0;
      for (int i = 0; i < H; i++) step();
      RST = 1'b1;
      step();
      chk("midact_act",   32'(obs_act), 32'd0);
      chk("midact_we",    32'(obs_we),  32'd0);
      chk("midact_flush", 32'(obs_fl),  32'd0);
      RST = 1'b0;
      find_act(act_idx);
      chk("midact_reboot_act_cycle", 32'(act_idx), 32'(H + 1));
      step();

      // Randomized traffic against the model, including occasional resets.
      for (int i = 0; i < 800; i++) begin
         RST            = ($urandom_range(0, 79) == 0);
         bus.TRAP_VLD   = ($urandom_range(0, 7) == 0);
         bus.TRAP_PC    = $urandom;
         bus.BR_VLD     = ($urandom_range(0, 5) == 0);
         bus.BR_PC      = $urandom;
         bus.FETCH_FIRE = $urandom_range(0, 1) == 1;
         bus.r_pc_Q     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : $urandom;
         bus.RSTU_PC_D  = $urandom;
         bus.RSTU_PC_WE = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) bus.DBG_HALT = !bus.DBG_HALT;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences and arbitrates every write to the architectural fetch PC register r_pc in the superscalar core.
- After reset it runs a hold/settle sequence, then fires the reset_t functional unit's ACT for one cycle so r_pc loads the boot vector.
- In normal operation it chooses among trap redirect, branch-mispredict redirect and sequential fetch-block advance, and emits flush and fetch-enable controls.
- Sits between the ca_main events (reset_t, trap unit, branch resolution) and the r_pc register; it is the only writer of r_pc.

Parameters:
- RESET_HOLD_CYCLES, 4, cycles spent in HOLD after RST deasserts before ACT fires (legal range 1..255).
- FETCH_BYTES, 8, fetch-block size in bytes; must be a power of 2, 4..64.

Ports:
- CLK  input  1  core clock
- RST  input  1  reset; synchronous, active-high
- RSTU_ACT  output  1  drives reset_t ACT
- RSTU_PC_D  input  32  r_pc data from reset_t
- RSTU_PC_WE  input  1  r_pc write enable from reset_t
- TRAP_VLD  input  1  trap/exception redirect request
- TRAP_PC  input  32  trap target
- BR_VLD  input  1  branch-mispredict redirect request
- BR_PC  input  32  branch target
- FETCH_FIRE  input  1  fetch accepted current block this cycle
- DBG_HALT  input  1  halt request (level)
- r_pc_Q  input  32  current r_pc value
- r_pc_D  output  32  r_pc write data
- r_pc_WE  output  1  r_pc write enable
- FETCH_EN  output  1  fetch may issue from r_pc_Q
- FLUSH  output  1  flush younger pipeline contents
- HALTED  output  1  core is in HALT state

Behaviour:
- FSM states: HOLD, ACT, START, RUN, HALT. While RST=1: state <= HOLD, counter <= RESET_HOLD_CYCLES-1.
- Output values while RST=1: all outputs 0 (RSTU_ACT, r_pc_WE, FETCH_EN, FLUSH, HALTED); r_pc_D=0.
- HOLD: decrement counter each cycle. When counter==0, go to ACT. All redirect and fetch inputs are ignored.
- ACT: RSTU_ACT=1 for exactly one cycle. r_pc_D/r_pc_WE pass through RSTU_PC_D/RSTU_PC_WE (0x00001000/1). FLUSH=1. Next state is START.
- START: the new r_pc is visible this cycle. FETCH_EN=0, no writes. Next state is RUN, or HALT if DBG_HALT=1.
- RUN: FETCH_EN=1. r_pc write sources, highest priority first:
  - TRAP_VLD: r_pc_D=TRAP_PC with bits[1:0] forced to 0; FLUSH=1.
  - BR_VLD: r_pc_D=BR_PC with bits[1:0] forced to 0; FLUSH=1.
  - FETCH_FIRE: r_pc_D = (r_pc_Q with low log2(FETCH_BYTES) bits cleared) + FETCH_BYTES.
  - None of the above: r_pc_WE=0.
- Write timing: r_pc_D/r_pc_WE are combinational from state and inputs; r_pc updates at the next CLK edge (zero-cycle controller latency).
- Redirect and fetch interaction:
  - A redirect in the same cycle as FETCH_FIRE wins; the sequential advance is dropped.
  - Simultaneous TRAP_VLD and BR_VLD: the trap wins, a single write occurs, FLUSH=1.
- Wrap-around: the sequential add is modulo 2^32 (block 0xFFFFFFF8 advances to 0x00000000). No overflow flag.
- Halting:
  - DBG_HALT=1 in RUN moves to HALT next cycle. A redirect or advance in that same cycle still commits.
  - HALT: FETCH_EN=0, HALTED=1, FETCH_FIRE ignored. TRAP_VLD/BR_VLD are still accepted with the same priority and FLUSH.
  - DBG_HALT=0 in HALT returns to RUN next cycle.
- RST asserted in any state, including mid-sequence in HOLD or ACT: HOLD restarts with a full count. An in-flight write is suppressed in that cycle.
- RSTU_PC_WE in any state other than ACT is ignored; r_pc_WE stays 0 unless the RUN/HALT rules above apply.
- FLUSH is combinational and high exactly in cycles where ACT occurs or a redirect write is issued.

Decomposition:
- Shared package pc_seq_pkg holds:
  - the state enum (HOLD/ACT/START/RUN/HALT);
  - BOOT_PC_ALIGN_MASK (32'hFFFFFFFC);
  - the source-select encoding (SRC_NONE, SRC_RESET, SRC_TRAP, SRC_BR, SRC_SEQ), shared with the trace/debug logic.
- One natural sub-module: pc_next_mux, a purely combinational priority select and alignment/increment unit producing r_pc_D, r_pc_WE, FLUSH and the source code. The FSM and counter stay in pc_sequencer.

Test Plan:
- Boot: RST=1 for 3 cycles then 0, defaults → RSTU_ACT high exactly on the 5th cycle after release; r_pc_WE=1 with D=0x00001000 that cycle; FETCH_EN first rises 2 cycles later.
- Sequential advance: RUN, r_pc_Q=0x00001004, FETCH_FIRE=1 → r_pc_D=0x00001008, r_pc_WE=1, FLUSH=0. Repeat with r_pc_Q=0xFFFFFFF8 → r_pc_D=0x00000000.
- Priority: TRAP_VLD=1 (TRAP_PC=0x80000003), BR_VLD=1 (BR_PC=0x2000) and FETCH_FIRE=1 in the same cycle → r_pc_D=0x80000000, FLUSH=1, single write.
- Branch only: BR_VLD=1 with BR_PC=0x00002010 and FETCH_FIRE=0 → r_pc_D=0x00002010, FLUSH=1.
- Halt: DBG_HALT=1 → next cycle HALTED=1, FETCH_EN=0, FETCH_FIRE pulses cause no writes. BR_VLD in HALT (BR_PC=0x3000) is still written. Release DBG_HALT → FETCH_EN=1 next cycle.
- Mid-sequence reset: assert RST during HOLD count 1 or during the ACT cycle → r_pc_WE=0 and RSTU_ACT=0 that cycle; after release, the full RESET_HOLD_CYCLES delay elapses again before ACT.
